jt03_wr_arb: RTL and testbench



---
 rtl/jt03_arb_pkg.sv | 29 ++
 rtl/jt03_arb_wait.sv | 49 ++++
 rtl/jt03_wr_arb.sv | 220 ++++++++++++++++++++++
 tb/tb_jt03_wr_arb.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt03_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jt03_arb_pkg
//  Description : Shared constants and FSM state type for the jt03 write
//                sequencer/arbiter (state encoding, counter width, number of
//                requesters).
//  Revision    : 1.0  initial release
// ============================================================================
package jt03_arb_pkg;

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_ADDR  = 3'd1;
  localparam logic [2:0] c_ST_AWAIT = 3'd2;
  localparam logic [2:0] c_ST_DATA  = 3'd3;
  localparam logic [2:0] c_ST_DWAIT = 3'd4;

  localparam int unsigned c_CNT_W   = 8;
  localparam int unsigned c_NUM_REQ = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = c_ST_IDLE,
    ST_ADDR  = c_ST_ADDR,
    ST_AWAIT = c_ST_AWAIT,
    ST_DATA  = c_ST_DATA,
    ST_DWAIT = c_ST_DWAIT
  } state_t;

endpackage
`default_nettype wire

// File: rtl/jt03_arb_wait.sv
`default_nettype none
// ============================================================================
//  Module      : jt03_arb_wait
//  Description : Loadable, cen-qualified 8-bit down-counter used for both the
//                post-address and post-data busy gaps. done_o is high while
//                the count sits at 1. The counter stops at 0, never wraps.
//  Revision    : 1.0  initial release
// ============================================================================
module jt03_arb_wait
  import jt03_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cen,
  input  logic               load_i,
  input  logic [c_CNT_W-1:0] load_val_i,
  input  logic               dec_i,
  output logic               done_o
);

  localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_ZERO = '0;

  logic [c_CNT_W-1:0] cnt_q;
  logic [c_CNT_W-1:0] cnt_d;

  // Next count: load has priority over decrement; hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != c_ZERO)) begin
      cnt_d = cnt_q - c_ONE;
    end
  end

  // Counter register, only advances on cen ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= c_ZERO;
    end else if (cen) begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == c_ONE);

endmodule
`default_nettype wire

// File: rtl/jt03_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : jt03_wr_arb
//  Description : Two-requester round-robin write arbiter/sequencer for the
//                jt03 (YM2203) core. Each accepted request becomes an address
//                strobe (addr=0) then a data strobe (addr=1), each followed
//                by a busy gap counted in cen ticks. All outputs registered.
//                Optional feature macro: JT03_ARB_SKIPADDR_EN (skip the
//                address phase when the register matches the last one
//                written).
//  Revision    : 1.0  initial release
// ============================================================================
module jt03_wr_arb
  import jt03_arb_pkg::*;
#(
  parameter int unsigned ADDR_WAIT = 6,
  parameter int unsigned DATA_WAIT = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       req0_valid,
  input  logic [7:0] req0_reg,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_reg,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] chip_din,
  output logic       chip_addr,
  output logic       chip_cs_n,
  output logic       chip_wr_n,
  output logic       busy
);

  localparam logic [c_CNT_W-1:0] c_AWAIT_LOAD = c_CNT_W'(ADDR_WAIT);
  localparam logic [c_CNT_W-1:0] c_DWAIT_LOAD = c_CNT_W'(DATA_WAIT);

  state_t                 state_q, state_d;
  logic [7:0]             data_q, data_d;
  logic                   prio_q, prio_d;
  logic                   cs_n_q, cs_n_d;
  logic                   wr_n_q, wr_n_d;
  logic                   addr_q, addr_d;
  logic [7:0]             din_q, din_d;
  logic [c_NUM_REQ-1:0]   rdy_q, rdy_d;
  logic                   busy_q, busy_d;

  logic                   w_any;
  logic                   w_gnt;
  logic [7:0]             w_sel_reg;
  logic [7:0]             w_sel_data;
  logic                   w_skip;
  logic                   w_accept;
  logic                   w_cnt_load;
  logic [c_CNT_W-1:0]     w_cnt_val;
  logic                   w_cnt_dec;
  logic                   w_cnt_done;

  // Round-robin pick: the priority pointer only matters when both are valid.
  assign w_any      = req0_valid | req1_valid;
  assign w_gnt      = (req0_valid & req1_valid) ? prio_q : ~req0_valid;
  assign w_sel_reg  = w_gnt ? req1_reg  : req0_reg;
  assign w_sel_data = w_gnt ? req1_data : req0_data;
  assign w_accept   = cen & (state_q == ST_IDLE) & w_any;

`ifdef JT03_ARB_SKIPADDR_EN
  logic [7:0] last_reg_q, last_reg_d;
  logic       last_vld_q, last_vld_d;

  // Remember the register most recently put on the bus by an address strobe.
  always_comb begin
    last_reg_d = last_reg_q;
    last_vld_d = last_vld_q;
    if (w_accept && !w_skip) begin
      last_reg_d = w_sel_reg;
      last_vld_d = 1'b1;
    end
  end

  // Last-address tracker; the flag is cleared by reset only.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg_q <= 8'h00;
      last_vld_q <= 1'b0;
    end else begin
      last_reg_q <= last_reg_d;
      last_vld_q <= last_vld_d;
    end
  end

  assign w_skip = last_vld_q & (w_sel_reg == last_reg_q);
`else
  assign w_skip = 1'b0;
`endif

  // Shared busy-gap counter for AWAIT and DWAIT.
  jt03_arb_wait u_wait (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .load_i     (w_cnt_load),
    .load_val_i (w_cnt_val),
    .dec_i      (w_cnt_dec),
    .done_o     (w_cnt_done)
  );

  // Next-state and next-output logic; nothing moves unless cen is high.
  // The register address needs no separate latch: din_q holds it for the
  // whole address phase, and only the data byte must survive until DATA.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    prio_d     = prio_q;
    cs_n_d     = cs_n_q;
    wr_n_d     = wr_n_q;
    addr_d     = addr_q;
    din_d      = din_q;
    rdy_d      = '0;
    w_cnt_load = 1'b0;
    w_cnt_val  = '0;
    w_cnt_dec  = 1'b0;
    if (cen) begin
      case (state_q)
        ST_IDLE: begin
          if (w_any) begin
            data_d       = w_sel_data;
            prio_d       = ~w_gnt;
            rdy_d[w_gnt] = 1'b1;
            cs_n_d       = 1'b0;
            wr_n_d       = 1'b0;
            if (w_skip) begin
              addr_d  = 1'b1;
              din_d   = w_sel_data;
              state_d = ST_DATA;
            end else begin
              addr_d  = 1'b0;
              din_d   = w_sel_reg;
              state_d = ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          cs_n_d     = 1'b1;
          wr_n_d     = 1'b1;
          w_cnt_load = 1'b1;
          w_cnt_val  = c_AWAIT_LOAD;
          state_d    = ST_AWAIT;
        end
        ST_AWAIT: begin
          if (w_cnt_done) begin
            cs_n_d  = 1'b0;
            wr_n_d  = 1'b0;
            addr_d  = 1'b1;
            din_d   = data_q;
            state_d = ST_DATA;
          end else begin
            w_cnt_dec = 1'b1;
          end
        end
        ST_DATA: begin
          cs_n_d     = 1'b1;
          wr_n_d     = 1'b1;
          w_cnt_load = 1'b1;
          w_cnt_val  = c_DWAIT_LOAD;
          state_d    = ST_DWAIT;
        end
        ST_DWAIT: begin
          if (w_cnt_done) begin
            state_d = ST_IDLE;
          end else begin
            w_cnt_dec = 1'b1;
          end
        end
        default: begin
          cs_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; ready is a single-clk pulse regardless of cen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= 8'h00;
      prio_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      addr_q  <= 1'b0;
      din_q   <= 8'h00;
      rdy_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      prio_q  <= prio_d;
      cs_n_q  <= cs_n_d;
      wr_n_q  <= wr_n_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign req0_ready = rdy_q[0];
  assign req1_ready = rdy_q[1];
  assign chip_din   = din_q;
  assign chip_addr  = addr_q;
  assign chip_cs_n  = cs_n_q;
  assign chip_wr_n  = wr_n_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_jt03_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jt03_wr_arb
//  Description : Randomized scoreboard bench for jt03_wr_arb. A cen-tick
//                reference model predicts grants, strobes and busy windows;
//                a negedge monitor compares DUT activity against them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_jt03_wr_arb;

  localparam int AW = 6;
  localparam int DW = 24;

  typedef struct {
    logic       a;
    logic [7:0] d;
    int         t;
  } strb_t;

  typedef struct {
    int who;
    int t;
  } rdy_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic       vld [2];
  logic [7:0] rg  [2];
  logic [7:0] dt  [2];
  logic       rdy0, rdy1;
  logic [7:0] din;
  logic       addr, cs_n, wr_n, busy;

  int errors = 0;
  int checks = 0;
  int cen_mode = 0;
  int cen_div = 0;

  strb_t sq[$];
  rdy_t  rq[$];

  jt03_wr_arb #(.ADDR_WAIT(AW), .DATA_WAIT(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .req0_valid (vld[0]),
    .req0_reg   (rg[0]),
    .req0_data  (dt[0]),
    .req0_ready (rdy0),
    .req1_valid (vld[1]),
    .req1_reg   (rg[1]),
    .req1_data  (dt[1]),
    .req1_ready (rdy1),
    .chip_din   (din),
    .chip_addr  (addr),
    .chip_cs_n  (cs_n),
    .chip_wr_n  (wr_n),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // cen pattern: 0 = always on, 1 = every 4th clk, 2 = random
  always @(negedge clk) begin
    case (cen_mode)
      0: cen = 1'b1;
      1: begin
        cen     = (cen_div == 3);
        cen_div = (cen_div + 1) % 4;
      end
      default: cen = ($urandom_range(0, 1) == 1);
    endcase
  end

  // Reference model, expressed in cen ticks: a write accepted at tick t owns
  // the bus until t+2+AW+DW; the address strobe is at t, the data strobe at
  // t+1+AW. Ties go to the requester not granted last.
  int         cur_tick   = -1;
  int         busy_until = -1;
  int         prio       = 0;
  bit         busy_exp   = 1'b0;
  int         m_g;
  bit         m_skip;
  logic [7:0] m_last     = 8'h00;
  bit         m_lv       = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      cur_tick   = -1;
      busy_until = -1;
      prio       = 0;
      busy_exp   = 1'b0;
      m_lv       = 1'b0;
      sq.delete();
      rq.delete();
    end else if (cen) begin
      cur_tick++;
      if (cur_tick > busy_until && (vld[0] || vld[1])) begin
        m_g    = (vld[0] && vld[1]) ? prio : (vld[0] ? 0 : 1);
        prio   = 1 - m_g;
        m_skip = 1'b0;
`ifdef JT03_ARB_SKIPADDR_EN
        m_skip = m_lv && (m_last == rg[m_g]);
        if (!m_skip) begin
          m_last = rg[m_g];
          m_lv   = 1'b1;
        end
`endif
        rq.push_back('{who: m_g, t: cur_tick});
        if (m_skip) begin
          sq.push_back('{a: 1'b1, d: dt[m_g], t: cur_tick});
          busy_until = cur_tick + 1 + DW;
        end else begin
          sq.push_back('{a: 1'b0, d: rg[m_g], t: cur_tick});
          sq.push_back('{a: 1'b1, d: dt[m_g], t: cur_tick + 1 + AW});
          busy_until = cur_tick + 2 + AW + DW;
        end
      end
      busy_exp = (cur_tick < busy_until);
    end
  end

  // Monitor: pops expectations whenever the DUT shows a ready or a strobe.
  logic  prev_cs_n = 1'b1;
  int    s_start   = 0;
  rdy_t  mr;
  strb_t ms;

  always @(negedge clk) begin
    if (rst) begin
      prev_cs_n = 1'b1;
    end else begin
      chk("busy", busy, busy_exp);
      chk("wr_n_vs_cs_n", wr_n, cs_n);
      if (rdy0 || rdy1) begin
        if (rq.size() == 0) begin
          chk("ready_unexpected", {rdy1, rdy0}, 0);
        end else begin
          mr = rq.pop_front();
          chk("ready_who", {rdy1, rdy0}, (mr.who == 1) ? 2 : 1);
          chk("ready_tick", cur_tick, mr.t);
        end
      end
      if (!cs_n && prev_cs_n) begin
        if (sq.size() == 0) begin
          chk("strobe_unexpected", cs_n, 1);
        end else begin
          ms = sq.pop_front();
          chk("strobe_addr", addr, ms.a);
          chk("strobe_din", din, ms.d);
          chk("strobe_tick", cur_tick, ms.t);
          s_start = cur_tick;
        end
      end
      if (cs_n && !prev_cs_n) begin
        chk("strobe_len", cur_tick - s_start, 1);
      end
      prev_cs_n = cs_n;
    end
  end

  task automatic issue(input int r, input logic [7:0] rv, input logic [7:0] dv);
    bit got;
    @(negedge clk);
    vld[r] = 1'b1;
    rg[r]  = rv;
    dt[r]  = dv;
    got    = 1'b0;
    for (int n = 0; n < 3000 && !got; n++) begin
      @(negedge clk);
      if ((r == 0) ? rdy0 : rdy1) got = 1'b1;
    end
    vld[r] = 1'b0;
    chk("ready_seen", got, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_wr_n", wr_n, 1);
    chk("rst_addr", addr, 0);
    chk("rst_din", din, 0);
    chk("rst_ready", {rdy1, rdy0}, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 1000 && !done; n++) begin
      @(negedge clk);
      if (!busy && sq.size() == 0 && rq.size() == 0) done = 1'b1;
    end
    chk("drain", done, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic rnd_req(input int r);
    repeat (6) begin
      repeat ($urandom_range(0, 40)) @(negedge clk);
      issue(r, 8'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int span_busy;
  int span_cs;

  initial begin
    vld[0] = 1'b0; vld[1] = 1'b0;
    rg[0]  = 8'h00; rg[1] = 8'h00;
    dt[0]  = 8'h00; dt[1] = 8'h00;
    cen_mode = 0;

    // reset values, then a single write from requester 0
    do_reset();
    issue(0, 8'h28, 8'hF0);
    wait_idle();

    // both requesters valid straight out of reset
    do_reset();
    fork
      begin
        issue(0, 8'h11, 8'h22);
        issue(0, 8'h33, 8'h44);
      end
      issue(1, 8'h55, 8'h66);
    join
    wait_idle();

    // cen every 4th clk: strobe and busy spans in clk cycles
    cen_mode = 1;
    span_busy = 0;
    span_cs = 0;
    fork
      issue(0, 8'h2D, 8'h9C);
      begin
        for (int n = 0; n < 200 && !busy; n++) @(negedge clk);
        for (int n = 0; n < 400 && busy; n++) begin
          span_busy++;
          @(negedge clk);
        end
      end
      begin
        for (int n = 0; n < 200 && cs_n; n++) @(negedge clk);
        for (int n = 0; n < 40 && !cs_n; n++) begin
          span_cs++;
          @(negedge clk);
        end
      end
    join
    chk("busy_span_clk", span_busy, 4 * (2 + AW + DW));
    chk("addr_strobe_clk", span_cs, 4);
    wait_idle();
    cen_mode = 0;

    // reset during AWAIT drops the write
    issue(0, 8'h0A, 8'h5A);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cs_n", cs_n, 1);
    chk("midrst_wr_n", wr_n, 1);
    chk("midrst_busy", busy, 0);
    rst = 1'b0;
    repeat (60) @(negedge clk);

    // requester 1 arrives while requester 0's write is in DWAIT
    fork
      issue(0, 8'h40, 8'h01);
      begin
        repeat (20) @(negedge clk);
        issue(1, 8'h41, 8'h02);
      end
    join
    wait_idle();

    // randomized traffic with random cen
    cen_mode = 2;
    fork
      rnd_req(0);
      rnd_req(1);
    join
    wait_idle();

    chk("strobe_queue_empty", sq.size(), 0);
    chk("ready_queue_empty", rq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
